// File: rtl/hs_df.sv
// ---------------------------------------------------------------------------
// hs_df -- one-bit half subtractor with registered outputs and statistics.
//
// Computes A - B as a difference bit and a borrow bit, both combinationally
// (usable with no clock at all), and also keeps registered copies plus two
// saturating counters: how many edges were sampled out of reset, and how
// many of those sampled a borrow.
//
// Parameters
//   CNT_W       width of both statistics counters (2..32)
//
// Ports (declaration order keeps Diff, Borrow, A, B first so a positional
// four-port hookup still binds the combinational subtractor)
//   Diff        out  A XOR B, combinational
//   Borrow      out  (NOT A) AND B, combinational
//   A           in   minuend bit
//   B           in   subtrahend bit
//   clk         in   rising-edge clock for all state
//   rst_n       in   synchronous active-low reset
//   Diff_q      out  Diff sampled on clk (one cycle latency)
//   Borrow_q    out  Borrow sampled on clk (one cycle latency)
//   borrow_cnt  out  saturating count of edges sampled with Borrow=1
//   sample_cnt  out  saturating count of edges sampled out of reset
// ---------------------------------------------------------------------------
module hs_df #(
  parameter int CNT_W = 8
) (
  output logic             Diff,
  output logic             Borrow,
  input  logic             A,
  input  logic             B,
  input  logic             clk,
  input  logic             rst_n,
  output logic             Diff_q,
  output logic             Borrow_q,
  output logic [CNT_W-1:0] borrow_cnt,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Pure gate function: no dependence on clk or rst_n, so it stays valid
  // during reset and with the clock stopped.
  assign Diff   = A ^ B;
  assign Borrow = ~A & B;

  // The reset branch sits inside the clocked block with rst_n absent from the
  // sensitivity list, so dropping rst_n between edges changes nothing until
  // the next rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so ordering inside this block does not matter.
      Diff_q     <= 1'b0;
      Borrow_q   <= 1'b0;
      borrow_cnt <= '0;
      sample_cnt <= '0;
    end else begin
      Diff_q   <= Diff;
      Borrow_q <= Borrow;
      // Both counters stop at all-ones instead of wrapping. borrow_cnt can
      // only advance on an edge where sample_cnt also advances or is already
      // saturated, so borrow_cnt <= sample_cnt holds at all times.
      if (sample_cnt != CNT_MAX) begin
        sample_cnt <= sample_cnt + 1'b1;
      end
      if (Borrow && (borrow_cnt != CNT_MAX)) begin
        borrow_cnt <= borrow_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hs_df.sv
// ---------------------------------------------------------------------------
// tb_hs_df -- self-checking bench for hs_df.
//
// Two instances share the stimulus: one at the default CNT_W=8 and one at
// CNT_W=4 so counter saturation is reached quickly. Expected values come from
// a reference model that tracks edge counts as plain integers and clamps
// them to the counter maximum, and derives the subtractor outputs from
// integer subtraction of A and B.
// ---------------------------------------------------------------------------
module tb_hs_df;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;

  logic       diff8, borrow8, diff_q8, borrow_q8;
  logic [7:0] bcnt8, scnt8;
  logic       diff4, borrow4, diff_q4, borrow_q4;
  logic [3:0] bcnt4, scnt4;

  int total = 0;
  int bad = 0;

  // Reference model state.
  int  n_samp = 0;
  int  n_borrow = 0;
  logic exp_dq = 1'b0;
  logic exp_bq = 1'b0;

  hs_df dut8 (
    .Diff(diff8), .Borrow(borrow8), .A(a), .B(b), .clk(clk), .rst_n(rst_n),
    .Diff_q(diff_q8), .Borrow_q(borrow_q8), .borrow_cnt(bcnt8), .sample_cnt(scnt8)
  );

  hs_df #(.CNT_W(4)) dut4 (
    .Diff(diff4), .Borrow(borrow4), .A(a), .B(b), .clk(clk), .rst_n(rst_n),
    .Diff_q(diff_q4), .Borrow_q(borrow_q4), .borrow_cnt(bcnt4), .sample_cnt(scnt4)
  );

  always #5 if (clk_en) clk = ~clk;

  // A - B over integers: the difference bit is the result modulo 2 and a
  // borrow is needed exactly when the result is negative.
  function automatic logic ref_diff(input logic x, input logic y);
    int d;
    d = int'(x) - int'(y);
    return (d != 0);
  endfunction

  function automatic logic ref_borrow(input logic x, input logic y);
    return (int'(x) - int'(y)) < 0;
  endfunction

  function automatic int clamp(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_comb(input string tag);
    check({tag, ".diff8"},   32'(diff8),   32'(ref_diff(a, b)));
    check({tag, ".borrow8"}, 32'(borrow8), 32'(ref_borrow(a, b)));
    check({tag, ".diff4"},   32'(diff4),   32'(ref_diff(a, b)));
    check({tag, ".borrow4"}, 32'(borrow4), 32'(ref_borrow(a, b)));
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".diff_q8"},   32'(diff_q8),   32'(exp_dq));
    check({tag, ".borrow_q8"}, 32'(borrow_q8), 32'(exp_bq));
    check({tag, ".scnt8"},     32'(scnt8),     32'(clamp(n_samp, 8)));
    check({tag, ".bcnt8"},     32'(bcnt8),     32'(clamp(n_borrow, 8)));
    check({tag, ".diff_q4"},   32'(diff_q4),   32'(exp_dq));
    check({tag, ".borrow_q4"}, 32'(borrow_q4), 32'(exp_bq));
    check({tag, ".scnt4"},     32'(scnt4),     32'(clamp(n_samp, 4)));
    check({tag, ".bcnt4"},     32'(bcnt4),     32'(clamp(n_borrow, 4)));
    check({tag, ".order8"},    32'(bcnt8 <= scnt8), 32'(1));
  endtask

  // One rising edge: update the model from the values present at the edge,
  // then check the registers 1 ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst_n) begin
      n_samp = 0; n_borrow = 0; exp_dq = 1'b0; exp_bq = 1'b0;
    end else begin
      exp_dq = ref_diff(a, b);
      exp_bq = ref_borrow(a, b);
      n_samp++;
      if (ref_borrow(a, b)) n_borrow++;
    end
    #1;
    check_regs(tag);
  endtask

  initial begin
    // No clock: combinational path alone, 100 ns per input pattern.
    for (int i = 0; i < 4; i++) begin
      {a, b} = 2'(i);
      #100;
      check_comb($sformatf("noclk%0d", i));
    end

    // Start the clock with reset held for two edges.
    clk_en = 1'b1;
    rst_n = 1'b0;
    a = 1'b1; b = 1'b1;
    tick("rst0");
    tick("rst1");
    #2;
    rst_n = 1'b1;
    a = 1'b0; b = 1'b1;
    tick("first");
    check("first.scnt_is_1", 32'(scnt8), 32'(1));
    check("first.bq_is_1", 32'(borrow_q8), 32'(1));

    // Fresh reset, then cycle all four patterns.
    #2; rst_n = 1'b0; tick("rst2");
    #2; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {a, b} = 2'(i);
      #1; check_comb($sformatf("cyc%0d", i));
      tick($sformatf("cyc%0d", i));
      #2;
    end
    check("cyc.scnt_is_4", 32'(scnt8), 32'(4));
    check("cyc.bcnt_is_1", 32'(bcnt8), 32'(1));

    // Hold a borrow for 20 edges: the 4-bit instance saturates at 15.
    a = 1'b0; b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick($sformatf("sat%0d", i));
      #2;
    end
    check("sat.scnt4_is_15", 32'(scnt4), 32'(15));
    check("sat.bcnt4_is_15", 32'(bcnt4), 32'(15));

    // Mid-cycle reset with saturated counters: nothing moves until the edge.
    @(negedge clk);
    rst_n = 1'b0;
    a = 1'b1; b = 1'b0;
    #1;
    check_comb("midrst");
    check_regs("midrst.hold");
    tick("midrst.edge");
    check("midrst.scnt4_is_0", 32'(scnt4), 32'(0));
    check_comb("inrst");
    #2; rst_n = 1'b1;

    // Random traffic with glitches between edges and occasional resets.
    for (int i = 0; i < 300; i++) begin
      int glitches;
      glitches = $urandom_range(0, 3);
      for (int g = 0; g < glitches; g++) begin
        {a, b} = 2'($urandom_range(0, 3));
        #1; check_comb("glitch");
      end
      {a, b} = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 39) != 0);
      #1; check_comb("rnd");
      tick("rnd");
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound in case the clock or a wait ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hs_df.md
HS_DF -- requirements
Module: hs_df

Interface
REQ-001 Parameter: CNT_W, default 8, width of the statistics counters (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: A  input  1  minuend bit.
REQ-005 Port: B  input  1  subtrahend bit.
REQ-006 Port: Diff  output  1  combinational difference, A minus B.
REQ-007 Port: Borrow  output  1  combinational borrow-out of A minus B.
REQ-008 Port: Diff_q  output  1  Diff registered on clk.
REQ-009 Port: Borrow_q  output  1  Borrow registered on clk.
REQ-010 Port: borrow_cnt  output  CNT_W  saturating count of clock edges sampled with Borrow=1.
REQ-011 Port: sample_cnt  output  CNT_W  saturating count of clock edges sampled out of reset.
REQ-012 Port declaration order SHALL be Diff, Borrow, A, B, clk, rst_n, Diff_q, Borrow_q, borrow_cnt, sample_cnt, so a positional 4-port hookup (Diff, Borrow, A, B) still binds the combinational path.

Function
REQ-013 Diff SHALL equal A XOR B, purely combinational, zero clock latency.
REQ-014 Borrow SHALL equal (NOT A) AND B, purely combinational, zero clock latency.
REQ-015 Truth table SHALL be A,B = 00 -> Diff 0, Borrow 0; 01 -> 1,1; 10 -> 1,0; 11 -> 0,0.
REQ-016 Diff and Borrow SHALL NOT depend on clk or rst_n; they are valid with the clock stopped or unconnected.
REQ-017 Diff_q and Borrow_q SHALL take the values of Diff and Borrow at each rising clk edge with rst_n=1, giving exactly one cycle of latency.
REQ-018 sample_cnt SHALL increment by 1 on each rising edge with rst_n=1, holding at 2^CNT_W-1 (no wrap).
REQ-019 borrow_cnt SHALL increment by 1 on each rising edge with rst_n=1 and Borrow=1, holding at 2^CNT_W-1 (no wrap).
REQ-020 borrow_cnt SHALL always be less than or equal to sample_cnt.
REQ-021 Input changes between clock edges SHALL affect only the combinational outputs; registered outputs and counters use only the value at the edge.

Reset
REQ-022 On a rising edge with rst_n=0: Diff_q=0, Borrow_q=0, borrow_cnt=0, sample_cnt=0; that edge SHALL NOT be counted.
REQ-023 Reset SHALL be synchronous only; asserting rst_n=0 between edges SHALL NOT change any register until the next rising edge.
REQ-024 Reset asserted mid-operation SHALL clear all registers on that edge regardless of count values or saturation.
REQ-025 Combinational Diff and Borrow SHALL remain the REQ-013/REQ-014 function during reset.

Verification
REQ-026 No clock. Apply A,B = 00, 01, 10, 11, 100 ns apart. Required Diff,Borrow after each step: 0,0; 1,1; 1,0; 0,0.
REQ-027 Hold rst_n=0 for 2 edges, then release. Required after the reset edges: Diff_q=0, Borrow_q=0, both counters 0. After release, one edge with A=0, B=1 gives Diff_q=1, Borrow_q=1, sample_cnt=1, borrow_cnt=1.
REQ-028 Out of reset, cycle A,B through 00,01,10,11 on four edges. Required: Diff_q,Borrow_q track one cycle behind; sample_cnt=4; borrow_cnt=1.
REQ-029 CNT_W=4, hold A=0, B=1 for 20 edges. Required: both counters saturate and stay at 15 with no wrap.
REQ-030 With counters nonzero, drop rst_n mid-cycle. Required: no change until the next edge, then all registers read 0. Diff/Borrow still follow A,B throughout.
REQ-031 Toggle A,B between edges (glitch). Required: Diff/Borrow follow immediately. Registers reflect only the edge-sampled values.
